// File: rtl/bus_arbiter_4_req_6_bit_if.sv
// Shared transfer channel between four sources and one consumer.
// master: arbiter side; slave: sources plus consumer side.
interface bus_arbiter_4_req_6_bit_if;
    logic [3:0] req;
    logic [5:0] i0;
    logic [5:0] i1;
    logic [5:0] i2;
    logic [5:0] i3;
    logic       out_ready;
    logic [5:0] out_data;
    logic       out_valid;
    logic [3:0] ack;
    logic [1:0] sel;
    logic       busy;

    modport master (
        input  req,
        input  i0,
        input  i1,
        input  i2,
        input  i3,
        input  out_ready,
        output out_data,
        output out_valid,
        output ack,
        output sel,
        output busy
    );

    modport slave (
        output req,
        output i0,
        output i1,
        output i2,
        output i3,
        output out_ready,
        input  out_data,
        input  out_valid,
        input  ack,
        input  sel,
        input  busy
    );
endinterface

// File: rtl/bus_arbiter_4_req_6_bit.sv
// Round-robin arbiter for a 4-source 6-bit channel with bounded bursts.
// One bubble cycle separates grants; the mux select is the registered grant.
module bus_arbiter_4_req_6_bit #(
    parameter int unsigned MAX_BURST = 4
) (
    input  logic clk,
    input  logic rst_n,
    bus_arbiter_4_req_6_bit_if.master bus
);
    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    localparam logic [3:0] LAST_BEAT = 4'(MAX_BURST - 1);

    state_e     state_q, state_d;
    logic [1:0] sel_q, sel_d;
    logic [1:0] last_q, last_d;
    logic [3:0] cnt_q, cnt_d;

    logic [1:0] pick;
    logic       hit;
    logic       req_sel;
    logic       valid;
    logic       xfer;

    // Scan starts just after the last winner and ends on it.
    always_comb begin
        pick = last_q;
        hit  = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            if (!hit && bus.req[last_q + 2'(k)]) begin
                pick = last_q + 2'(k);
                hit  = 1'b1;
            end
        end
    end

    assign req_sel = bus.req[sel_q];
    assign valid   = (state_q == GRANT) && req_sel;
    assign xfer    = valid && bus.out_ready;

    assign bus.out_valid = valid;
    assign bus.ack       = xfer ? (4'b0001 << sel_q) : 4'b0000;
    assign bus.sel       = sel_q;
    assign bus.busy      = (state_q == GRANT);

    always_comb begin
        bus.out_data = bus.i0;
        unique case (sel_q)
            2'd0: bus.out_data = bus.i0;
            2'd1: bus.out_data = bus.i1;
            2'd2: bus.out_data = bus.i2;
            2'd3: bus.out_data = bus.i3;
        endcase
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (hit) begin
                    state_d = GRANT;
                    sel_d   = pick;
                    cnt_d   = 4'd0;
                end
            end
            GRANT: begin
                // A dropped request releases without an ack.
                if (!req_sel) begin
                    state_d = IDLE;
                    last_d  = sel_q;
                end else if (xfer) begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == LAST_BEAT) begin
                        state_d = IDLE;
                        last_d  = sel_q;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= 2'd0;
            last_q  <= 2'd3;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_bus_arbiter_4_req_6_bit.sv
// Bench for bus_arbiter_4_req_6_bit: directed scenarios then random traffic.
// Two instances (bursts of 4 and of 1) share stimulus and are both modelled.
module tb_bus_arbiter_4_req_6_bit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [3:0] req;
    logic       rdy;
    logic [5:0] d [4];

    bus_arbiter_4_req_6_bit_if b4 ();
    bus_arbiter_4_req_6_bit_if b1 ();

    assign b4.req = req;
    assign b4.out_ready = rdy;
    assign b4.i0 = d[0];
    assign b4.i1 = d[1];
    assign b4.i2 = d[2];
    assign b4.i3 = d[3];
    assign b1.req = req;
    assign b1.out_ready = rdy;
    assign b1.i0 = d[0];
    assign b1.i1 = d[1];
    assign b1.i2 = d[2];
    assign b1.i3 = d[3];

    bus_arbiter_4_req_6_bit #(.MAX_BURST(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b4.master)
    );

    bus_arbiter_4_req_6_bit #(.MAX_BURST(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b1.master)
    );

    int n_assert = 0;
    int n_fail = 0;

    // Reference model: who holds the channel, beats so far, last winner.
    int m_busy [2];
    int m_sel [2];
    int m_last [2];
    int m_cnt [2];
    int mb [2] = '{4, 1};
    int acks [2] = '{0, 0};
    int gq0 [$];
    int gq1 [$];

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        for (int n = 0; n < 2; n++) begin
            m_busy[n] = 0;
            m_sel[n] = 0;
            m_last[n] = 3;
            m_cnt[n] = 0;
        end
    endtask

    task automatic check_inst(input int n);
        logic [3:0] ar;
        logic [5:0] od;
        logic ov;
        logic bz;
        logic [1:0] sl;
        logic ev;
        logic [3:0] ea;
        if (n == 0) begin
            ar = b4.ack; od = b4.out_data; ov = b4.out_valid;
            bz = b4.busy; sl = b4.sel;
        end else begin
            ar = b1.ack; od = b1.out_data; ov = b1.out_valid;
            bz = b1.busy; sl = b1.sel;
        end
        ev = (m_busy[n] != 0) && req[m_sel[n]];
        ea = (ev && rdy) ? 4'(1 << m_sel[n]) : 4'd0;
        chk($sformatf("valid%0d", n), 8'(ov), 8'(ev));
        chk($sformatf("ack%0d", n), 8'(ar), 8'(ea));
        chk($sformatf("busy%0d", n), 8'(bz), 8'(m_busy[n] != 0));
        chk($sformatf("sel%0d", n), 8'(sl), 8'(m_sel[n]));
        chk($sformatf("data%0d", n), 8'(od), 8'(d[m_sel[n]]));
        if (ar != 4'd0) acks[n]++;
        if (m_busy[n] == 0) begin
            for (int k = 1; k <= 4; k++) begin
                int idx;
                idx = (m_last[n] + k) % 4;
                if (m_busy[n] == 0 && req[idx]) begin
                    m_busy[n] = 1;
                    m_sel[n] = idx;
                    m_cnt[n] = 0;
                    if (n == 0) gq0.push_back(idx);
                    else gq1.push_back(idx);
                end
            end
        end else if (!req[m_sel[n]]) begin
            m_busy[n] = 0;
            m_last[n] = m_sel[n];
        end else if (ev && rdy) begin
            m_cnt[n]++;
            if (m_cnt[n] == mb[n]) begin
                m_busy[n] = 0;
                m_last[n] = m_sel[n];
            end
        end
    endtask

    // Called at a falling edge after inputs are set; returns at the next one.
    task automatic cyc();
        #1;
        check_inst(0);
        check_inst(1);
        @(negedge clk);
    endtask

    initial begin
        int a0;
        int rr [5] = '{0, 1, 2, 3, 0};
        int alt [4] = '{0, 1, 0, 1};
        req = 4'd0;
        rdy = 1'b0;
        d[0] = 6'h11; d[1] = 6'h22; d[2] = 6'h33; d[3] = 6'h3C;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy", 8'(b4.busy), 8'd0);
        chk("rst_sel", 8'(b4.sel), 8'd0);
        chk("rst_valid", 8'(b4.out_valid), 8'd0);
        chk("rst_ack", 8'(b4.ack), 8'd0);
        chk("rst_data", 8'(b4.out_data), 8'h11);
        rst_n = 1'b1;
        @(negedge clk);

        req = 4'b0001; d[0] = 6'h2A; rdy = 1'b1;
        cyc();
        #1;
        chk("first_busy", 8'(b4.busy), 8'd1);
        chk("first_data", 8'(b4.out_data), 8'h2A);
        chk("first_ack", 8'(b4.ack), 8'h01);
        cyc();
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 8'(b4.out_valid), 8'd0);
        chk("arst_ack", 8'(b4.ack), 8'd0);
        chk("arst_busy", 8'(b4.busy), 8'd0);
        chk("arst_sel", 8'(b4.sel), 8'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        req = 4'd0;
        cyc();

        gq0.delete(); gq1.delete();
        a0 = acks[0];
        req = 4'hF; rdy = 1'b1;
        repeat (25) cyc();
        chk("rr_acks", 8'(acks[0] - a0), 8'd20);
        chk("rr_grants", 8'(gq0.size()), 8'd5);
        for (int g = 0; g < 5; g++)
            chk($sformatf("rr_order%0d", g), 8'(gq0[g]), 8'(rr[g]));
        req = 4'd0;
        cyc();

        gq0.delete();
        a0 = acks[0];
        req = 4'b0100;
        repeat (3) cyc();
        req = 4'd0;
        cyc();
        chk("early_acks", 8'(acks[0] - a0), 8'd2);
        chk("early_src", 8'(gq0[0]), 8'd2);
        req = 4'b0101;
        cyc();
        #1;
        chk("after_early_sel", 8'(b4.sel), 8'd0);
        chk("after_early_busy", 8'(b4.busy), 8'd1);
        cyc();
        req = 4'd0;
        cyc();

        req = 4'b0010; rdy = 1'b0;
        cyc();
        repeat (5) begin
            #1;
            chk("bp_valid", 8'(b4.out_valid), 8'd1);
            chk("bp_ack", 8'(b4.ack), 8'd0);
            chk("bp_sel", 8'(b4.sel), 8'd1);
            cyc();
        end
        rdy = 1'b1;
        #1;
        chk("bp_release_ack", 8'(b4.ack), 8'h02);
        a0 = acks[0];
        repeat (4) cyc();
        chk("bp_beats", 8'(acks[0] - a0), 8'd4);
        req = 4'd0;
        cyc();

        a0 = acks[0];
        req = 4'b1000; rdy = 1'b0;
        repeat (2) cyc();
        req = 4'b0110;
        #1;
        chk("abort_ack", 8'(b4.ack), 8'd0);
        cyc();
        #1;
        chk("abort_busy", 8'(b4.busy), 8'd0);
        cyc();
        #1;
        chk("abort_next_sel", 8'(b4.sel), 8'd1);
        chk("abort_no_ack", 8'(acks[0] - a0), 8'd0);
        req = 4'd0;
        repeat (2) cyc();

        rst_n = 1'b0;
        #1;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        gq1.delete();
        a0 = acks[1];
        req = 4'b0011; rdy = 1'b1;
        repeat (8) cyc();
        chk("mb1_grants", 8'(gq1.size()), 8'd4);
        for (int g = 0; g < 4; g++)
            chk($sformatf("mb1_order%0d", g), 8'(gq1[g]), 8'(alt[g]));
        chk("mb1_beats", 8'(acks[1] - a0), 8'd4);
        req = 4'd0;
        cyc();

        repeat (400) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            rdy = ($urandom_range(0, 3) != 0);
            for (int s = 0; s < 4; s++) d[s] = 6'($urandom_range(0, 63));
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end
endmodule
